pipeline_hazard_ctrl: RTL

//  Parametrised stall/flush controller for the pipelined datapath; successor to the fixed 5-stage hazard logic.

---
 rtl/cpu_types_pkg.sv | 15 +
 rtl/pipeline_hazard_ctrl_if.sv | 41 ++++
 rtl/muldiv_stall_counter.sv | 29 ++
 rtl/pipeline_hazard_ctrl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared types for the pipeline hazard controller
// Contents: hazard_state_t (RUN/MULDIV/HALT controller state), REGBITS_W and
// regbits_t (register-index type).
package cpu_types_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_MULDIV = 2'd1,
        ST_HALT   = 2'd2
    } hazard_state_t;

    localparam int REGBITS_W = 5;
    typedef logic [REGBITS_W-1:0] regbits_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - pipeline status in, stall/flush control out
// Ports (signals): ihit, dhit, dmem_busy, dec_valid, dec_rs, dec_rt, dec_muldiv,
// ex_wen, ex_wsel, ex_dren, mem_wen, mem_wsel, redirect, halt (pipeline -> ctrl);
// pc_enable, lat_enable, lat_flush, muldiv_busy, halted (ctrl -> pipeline).
// Modports: master = pipeline side, slave = hazard controller.
interface pipeline_hazard_ctrl_if #(
    parameter int NUM_STAGES = 5,
    parameter int REG_W      = 5
);
    logic                  ihit;
    logic                  dhit;
    logic                  dmem_busy;
    logic                  dec_valid;
    logic [REG_W-1:0]      dec_rs;
    logic [REG_W-1:0]      dec_rt;
    logic                  dec_muldiv;
    logic                  ex_wen;
    logic [REG_W-1:0]      ex_wsel;
    logic                  ex_dren;
    logic                  mem_wen;
    logic [REG_W-1:0]      mem_wsel;
    logic                  redirect;
    logic                  halt;
    logic                  pc_enable;
    logic [NUM_STAGES-2:0] lat_enable;
    logic [NUM_STAGES-2:0] lat_flush;
    logic                  muldiv_busy;
    logic                  halted;

    modport master (
        output ihit, dhit, dmem_busy, dec_valid, dec_rs, dec_rt, dec_muldiv,
               ex_wen, ex_wsel, ex_dren, mem_wen, mem_wsel, redirect, halt,
        input  pc_enable, lat_enable, lat_flush, muldiv_busy, halted
    );

    modport slave (
        input  ihit, dhit, dmem_busy, dec_valid, dec_rs, dec_rt, dec_muldiv,
               ex_wen, ex_wsel, ex_dren, mem_wen, mem_wsel, redirect, halt,
        output pc_enable, lat_enable, lat_flush, muldiv_busy, halted
    );
endinterface

// File: rtl/muldiv_stall_counter.sv
// rtl/muldiv_stall_counter.sv - EX occupancy down-counter for multi-cycle mul/div
// Ports: clk, rst (async, active-high), load (count <= MULDIV_CYCLES-1),
// dec_en (decrement, saturating at 0), zero (count == 0).
module muldiv_stall_counter #(
    parameter int MULDIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec_en,
    output logic zero
);
    localparam int CNT_W = $clog2(MULDIV_CYCLES);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MULDIV_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (dec_en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - parametrised stall/flush controller with mul/div and halt FSM
// Ports: clk, rst (async, active-high), hz (pipeline_hazard_ctrl_if.slave).
// Option macro FORWARDING_EN: when defined only load-use stalls; otherwise any
// RAW against EX or MEM stalls until the producer reaches writeback.
module pipeline_hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int NUM_STAGES    = 5,
    parameter int REG_W         = 5,
    parameter int BRANCH_STAGE  = 2,
    parameter int MULDIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int NL = NUM_STAGES - 1;

    hazard_state_t state, state_next;

    logic [REG_W-1:0] dec_rs, dec_rt, ex_wsel, mem_wsel;
    logic             raw_ex, raw_mem, data_hazard, freeze;
    logic             pc_en, cnt_load, cnt_dec, cnt_zero;
    logic [NL-1:0]    lat_en, lat_fl;

    assign dec_rs   = hz.dec_rs;
    assign dec_rt   = hz.dec_rt;
    assign ex_wsel  = hz.ex_wsel;
    assign mem_wsel = hz.mem_wsel;

    // Register 0 is hardwired, so a write to it never creates a dependency.
    assign raw_ex  = hz.dec_valid && hz.ex_wen && (ex_wsel != '0) &&
                     ((ex_wsel == dec_rs) || (ex_wsel == dec_rt));
    assign raw_mem = hz.dec_valid && hz.mem_wen && (mem_wsel != '0) &&
                     ((mem_wsel == dec_rs) || (mem_wsel == dec_rt));

`ifdef FORWARDING_EN
    assign data_hazard = raw_ex && hz.ex_dren;
`else
    assign data_hazard = raw_ex || raw_mem;
`endif

    // An outstanding data access stalls the whole pipe in place.
    assign freeze = hz.dmem_busy && !hz.dhit;

    muldiv_stall_counter #(
        .MULDIV_CYCLES (MULDIV_CYCLES)
    ) u_counter (
        .clk    (clk),
        .rst    (rst),
        .load   (cnt_load),
        .dec_en (cnt_dec),
        .zero   (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_en      = 1'b0;
        lat_en     = '0;
        lat_fl     = '0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;

        if (!rst && (state != ST_HALT) && !freeze) begin
            case (state)
                ST_RUN: begin
                    if (hz.redirect && hz.ihit) begin
                        // Squash everything younger than the resolving stage,
                        // including a mul/div still sitting in decode.
                        pc_en  = 1'b1;
                        lat_en = '1;
                        for (int k = 0; k < NL; k++) begin
                            lat_fl[k] = (k < BRANCH_STAGE);
                        end
                    end else if (data_hazard) begin
                        // Hold PC and IF/ID, send a bubble into EX.
                        for (int k = 0; k < NL; k++) begin
                            lat_en[k] = (k != 0);
                            lat_fl[k] = (k == 1);
                        end
                    end else if (!hz.ihit) begin
                        lat_en    = '1;
                        lat_fl[0] = 1'b1;
                    end else begin
                        pc_en  = 1'b1;
                        lat_en = '1;
                        if (hz.dec_valid && hz.dec_muldiv) begin
                            cnt_load   = 1'b1;
                            state_next = ST_MULDIV;
                        end
                    end
                end
                ST_MULDIV: begin
                    // EX is occupied: hold everything up to ID/EX, drain the
                    // rest of the pipe with bubbles behind the mul/div.
                    for (int k = 0; k < NL; k++) begin
                        lat_en[k] = (k >= 2);
                        lat_fl[k] = (k == 2);
                    end
                    cnt_dec = 1'b1;
                    if (cnt_zero) begin
                        state_next = ST_RUN;
                    end
                end
                default: begin
                end
            endcase
        end

        // Halt is taken even while frozen; only reset leaves HALT.
        if (hz.halt) begin
            state_next = ST_HALT;
        end
    end

    assign hz.pc_enable   = pc_en;
    assign hz.lat_enable  = lat_en;
    assign hz.lat_flush   = lat_fl;
    assign hz.muldiv_busy = (state == ST_MULDIV);
    assign hz.halted      = (state == ST_HALT);
endmodule
